// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues loads/stores on a req/ack data bus,
// formats load data and presents the writeback triple to the MEM/WB register.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_memrd,
    input  logic        ex_memwr,
    input  logic [2:0]  ex_memtype,
    input  logic [31:0] ex_aluresult,
    input  logic [31:0] ex_wdata,
    input  logic        ex_regwr,
    input  logic [4:0]  ex_regdst_addr,
    output logic        mem_regwr,
    output logic [31:0] mem_data,
    output logic [4:0]  mem_regdst_addr,
    output logic        mem_stall,
    output logic        mem_addr_err,
    output logic        mem_bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_rdata;
    logic        r_bus_err, w_bus_err_nxt;
    logic        w_busy, w_capture;

    logic        w_is_byte, w_is_half, w_unsigned, w_memop, w_misaligned, w_access;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_is_byte    = (ex_memtype == 3'b000) || (ex_memtype == 3'b100);
    assign w_is_half    = (ex_memtype == 3'b001) || (ex_memtype == 3'b101);
    assign w_unsigned   = ex_memtype[2];
    assign w_memop      = ex_memrd | ex_memwr;
    assign w_misaligned = w_is_half ? ex_aluresult[0]
                        : (!w_is_byte && (ex_aluresult[1:0] != 2'b00));
    assign w_access     = w_memop & ~w_misaligned;

    // Per-lane byte enable and store-data replication.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign dbus_be[i] = w_is_byte ? (ex_aluresult[1:0] == 2'(i))
                          : w_is_half ? (ex_aluresult[1] == 1'(i / 2))
                          : 1'b1;
        assign dbus_wdata[8*i +: 8] = w_is_byte ? ex_wdata[7:0]
                                    : w_is_half ? ex_wdata[8*(i%2) +: 8]
                                    : ex_wdata[8*i +: 8];
    end

    assign dbus_addr = {ex_aluresult[31:2], 2'b00};
    assign dbus_we   = ex_memwr;

    always_comb begin
        w_byte = r_rdata[7:0];
        case (ex_aluresult[1:0])
            2'd0: w_byte = r_rdata[7:0];
            2'd1: w_byte = r_rdata[15:8];
            2'd2: w_byte = r_rdata[23:16];
            2'd3: w_byte = r_rdata[31:24];
            default: w_byte = r_rdata[7:0];
        endcase
        w_half = ex_aluresult[1] ? r_rdata[31:16] : r_rdata[15:0];
        if (w_is_byte)
            w_load = {{24{~w_unsigned & w_byte[7]}}, w_byte};
        else if (w_is_half)
            w_load = {{16{~w_unsigned & w_half[15]}}, w_half};
        else
            w_load = r_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_rdata   <= 32'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_nxt;
            r_bus_err <= w_bus_err_nxt;
            if (w_capture)
                r_rdata <= dbus_rdata;
        end
    end

    // Ack has priority over the timeout when both land in the same WAIT cycle.
    always_comb begin
        w_next        = r_state;
        w_cnt_nxt     = r_cnt;
        w_bus_err_nxt = r_bus_err;
        w_busy        = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_bus_err_nxt = 1'b0;
                if (w_access) begin
                    w_busy = 1'b1;
                    if (dbus_ack) begin
                        w_capture = 1'b1;
                        w_next    = S_DONE;
                    end else begin
                        w_cnt_nxt = 8'd0;
                        w_next    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_busy    = 1'b1;
                w_cnt_nxt = r_cnt + 8'd1;
                if (dbus_ack) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                    w_bus_err_nxt = 1'b1;
                    w_next        = S_DONE;
                end
            end
            S_DONE: begin
                w_bus_err_nxt = 1'b0;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request and stall drop as soon as reset asserts, even mid-access.
    assign dbus_req        = w_busy & reset;
    assign mem_stall       = w_busy & reset;
    assign mem_addr_err    = w_memop & w_misaligned;
    assign mem_bus_err     = r_bus_err;
    assign mem_regdst_addr = ex_regdst_addr;

    always_comb begin
        mem_data  = ex_aluresult;
        mem_regwr = ex_regwr;
        if (w_busy || mem_addr_err) begin
            mem_regwr = 1'b0;
        end else if (r_state == S_DONE) begin
            mem_regwr = ex_memrd & ex_regwr & ~r_bus_err;
            if (ex_memrd)
                mem_data = w_load;
        end
    end
endmodule
